// File: rtl/pes_mul_pkg.sv
// rtl/pes_mul_pkg.sv - shared constants, id width helper and tag type for the multiplier arbiter
package pes_mul_pkg;

  localparam int DATA_W   = 32;
  localparam int MAX_ID_W = 3;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/pes_mul_rsp_fifo.sv
// rtl/pes_mul_rsp_fifo.sv - first-word-fall-through response FIFO, pointers wrap modulo DEPTH
module pes_mul_rsp_fifo
  import pes_mul_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign rd_valid = (count != '0);
  assign push     = wr_en && (count != CNT_W'(DEPTH));
  assign pop      = rd_en && rd_valid;
  // Empty head reads as zero so rsp_id/rsp_data come out of reset clean.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pes_mul_arbiter.sv
// rtl/pes_mul_arbiter.sv - round-robin sharing of one fixed-latency multiplier among NUM_REQ requesters
// Optional grant/stall statistics ports exist only when PES_MUL_ARB_STATS_EN is defined.
module pes_mul_arbiter
  import pes_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           mul_a,
  output logic [DATA_W-1:0]           mul_b,
  input  logic [DATA_W-1:0]           mul_f,
  output logic                        rsp_valid,
  output logic [id_w(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        rsp_ready,
  output logic                        busy
`ifdef PES_MUL_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_issued,
  output logic [31:0]                 stat_stall
`endif
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
  end

  logic [ID_W-1:0]  rr;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic             credit_ok;
  logic             grant;
  logic             pop;

  assign credit_ok = (cnt < CNT_W'(FIFO_DEPTH));
  assign grant     = found && credit_ok && !rst;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (cnt != '0);

  // First valid requester at or after rr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((int'(rr) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[sel] = 1'b1;
    end
  end

  tag_t issue_tag;
  tag_t tag_pipe [PIPE_LAT];
  tag_t tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      issue_tag <= '0;
      cnt       <= '0;
    end else begin
      if (grant) begin
        rr        <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        mul_a     <= a_arr[sel];
        mul_b     <= b_arr[sel];
        issue_tag <= '{valid: 1'b1, id: MAX_ID_W'(sel)};
      end else begin
        issue_tag <= '0;
      end
      case ({grant, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Tag rides alongside the operands so the tail lines up with mul_f.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign tail = tag_pipe[PIPE_LAT-1];

  logic unused_tail_id;
  assign unused_tail_id = ^tail.id;

  logic [ID_W+DATA_W-1:0] head;

  pes_mul_rsp_fifo #(
    .WIDTH (ID_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (tail.valid),
    .wr_data  ({tail.id[ID_W-1:0], mul_f}),
    .rd_en    (rsp_ready),
    .rd_valid (rsp_valid),
    .rd_data  (head)
  );

  assign rsp_id   = head[DATA_W +: ID_W];
  assign rsp_data = head[DATA_W-1:0];

`ifdef PES_MUL_ARB_STATS_EN
  logic stall;
  assign stall = (|req_valid) && !credit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant && (stat_issued != 32'hFFFF_FFFF)) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (stall && (stat_stall != 32'hFFFF_FFFF)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pes_mul_arbiter.sv
// tb/tb_pes_mul_arbiter.sv - directed vectors and multi-cycle sequences for pes_mul_arbiter
module tb_pes_mul_arbiter;
  import pes_mul_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int PIPE_LAT   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ID_W       = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*32-1:0]  req_a;
  logic [NUM_REQ*32-1:0]  req_b;
  logic [NUM_REQ-1:0]     req_ready;
  logic [31:0]            mul_a;
  logic [31:0]            mul_b;
  logic [31:0]            mul_f;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [31:0]            rsp_data;
  logic                   rsp_ready;
  logic                   busy;
`ifdef PES_MUL_ARB_STATS_EN
  logic [31:0]            stat_issued;
  logic [31:0]            stat_stall;
`endif

  always #5 clk = ~clk;

  pes_mul_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_f     (mul_f),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef PES_MUL_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  // Multiplier stand-in: PIPE_LAT register stages, low 32 bits of A*B.
  logic [31:0] mpipe [PIPE_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_a * mul_b;
    for (int k = 1; k < PIPE_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_f = mpipe[PIPE_LAT-1];

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] exp_ready;
  } arb_vec_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } rsp_t;

  arb_vec_t vecs [13];
  rsp_t     exp_q [$];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       n_grant = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int seed);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*32 +: 32] = 32'h100 * (i + 1) + seed;
      req_b[i*32 +: 32] = seed + i + 2;
    end
  endtask

  // Called mid-cycle: log handshakes into the scoreboard, check any popped response.
  task automatic observe();
    rsp_t e;
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = ID_W'(i);
        e.data = req_a[i*32 +: 32] * req_b[i*32 +: 32];
        exp_q.push_back(e);
        n_grant++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    n_grant = 0;
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      observe();
      step();
    end
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    #1;
    chk({name, "_rsp_valid_end"}, 64'(rsp_valid), 64'd0);
    chk({name, "_busy_end"}, 64'(busy), 64'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0100, 4'b0100};
    vecs[1]  = '{4'b0000, 4'b0000};
    vecs[2]  = '{4'b0010, 4'b0010};
    vecs[3]  = '{4'b1111, 4'b0100};
    vecs[4]  = '{4'b1111, 4'b1000};
    vecs[5]  = '{4'b1111, 4'b0001};
    vecs[6]  = '{4'b1111, 4'b0010};
    vecs[7]  = '{4'b1111, 4'b0100};
    vecs[8]  = '{4'b0011, 4'b0001};
    vecs[9]  = '{4'b1001, 4'b1000};
    vecs[10] = '{4'b1001, 4'b0001};
    vecs[11] = '{4'b0110, 4'b0010};
    vecs[12] = '{4'b0001, 4'b0001};

    // Single op: reset values, issue, exact result latency.
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    step();
    step();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    req_valid = 4'b0001;
    req_a[31:0] = 32'h10;
    req_b[31:0] = 32'h1;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    #1;
    chk("single_mul_a", 64'(mul_a), 64'h10);
    chk("single_mul_b", 64'(mul_b), 64'h1);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_rsp_t0", 64'(rsp_valid), 64'd0);
    for (int n = 1; n <= PIPE_LAT; n++) begin
      step();
      #1;
      chk("single_rsp_early", 64'(rsp_valid), 64'd0);
    end
    step();
    #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_id", 64'(rsp_id), 64'd0);
    chk("single_rsp_data", 64'(rsp_data), 64'h10);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    chk("single_popped", 64'(rsp_valid), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);

    // Table: round-robin rotation, sparse requests and wrap, scoreboarded responses.
    do_reset();
    rsp_ready = 1'b1;
    for (int r = 0; r < 13; r++) begin
      req_valid = vecs[r].valid;
      set_ops(r + 1);
      observe();
      chk($sformatf("arb_row%0d", r), 64'(req_ready), 64'(vecs[r].exp_ready));
      step();
    end
    drain("arb");

    // Back-pressure: exactly FIFO_DEPTH grants, then none, even when a pop lands at full.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_a[31:0] = 32'hF0;
    req_b[31:0] = 32'h40;
    for (int k = 0; k < 20; k++) begin
      observe();
      step();
    end
    chk("bp_grants", 64'(n_grant), 64'(FIFO_DEPTH));
    #1;
    chk("bp_ready_off", 64'(req_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
`ifdef PES_MUL_ARB_STATS_EN
    chk("bp_stat_issued", 64'(stat_issued), 64'(FIFO_DEPTH));
    chk("bp_stat_stall", 64'(stat_stall), 64'd12);
`endif
    rsp_ready = 1'b1;
    observe();
    chk("bp_full_pop_no_grant", 64'(req_ready), 64'd0);
    step();
    drain("bp");

    // Pop and grant together at cnt == FIFO_DEPTH-1.
    do_reset();
    rsp_ready = 1'b0;
    req_b[31:0] = 32'h3;
    for (int k = 0; k < FIFO_DEPTH - 1; k++) begin
      req_valid = 4'b0001;
      req_a[31:0] = 32'(k + 1);
      observe();
      step();
    end
    req_valid = '0;
    step();
    step();
    req_valid = 4'b0001;
    req_a[31:0] = 32'h100;
    rsp_ready = 1'b1;
    observe();
    chk("pg_head_valid", 64'(rsp_valid), 64'd1);
    chk("pg_grant_with_pop", 64'(req_ready), 64'b0001);
    step();
    rsp_ready = 1'b0;
    req_a[31:0] = 32'h200;
    observe();
    chk("pg_grant_to_full", 64'(req_ready), 64'b0001);
    step();
    req_a[31:0] = 32'h300;
    observe();
    chk("pg_full_stop", 64'(req_ready), 64'd0);
    step();
`ifdef PES_MUL_ARB_STATS_EN
    chk("pg_stat_issued", 64'(stat_issued), 64'(FIFO_DEPTH + 1));
`endif
    drain("pg");

    // Reset while three ops are in the tag chain.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0111;
    set_ops(7);
    for (int k = 0; k < 3; k++) begin
      observe();
      step();
    end
    rst = 1'b1;
    req_valid = 4'b1111;
    exp_q.delete();
    #1;
    chk("mid_rst_no_grant", 64'(req_ready), 64'd0);
    step();
    step();
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      step();
    end
    req_valid = 4'b1111;
    set_ops(9);
    observe();
    chk("mid_rst_regrant", 64'(req_ready), 64'b0001);
    step();
`ifdef PES_MUL_ARB_STATS_EN
    chk("mid_rst_stat_issued", 64'(stat_issued), 64'd1);
`endif
    drain("mid_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
